// File: rtl/systolic_tile_sequencer.sv
// systolic_tile_sequencer: loads one weight tile, then streams skewed activation tiles
// through an NxN weight-stationary array and hands each accumulator result downstream.
module systolic_tile_sequencer #(
  parameter int N       = 4,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 8,
  parameter int BATCH_W = 4,
  parameter int ARR_LAT = 2*N
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        cfg_wbase,
  input  logic [ADDR_W-1:0]        cfg_abase,
  input  logic [BATCH_W-1:0]       cfg_batches,
  output logic                     busy,
  output logic                     done,
  output logic                     wbuf_rd,
  output logic [ADDR_W-1:0]        wbuf_addr,
  input  logic [N*DATA_W-1:0]      wbuf_rdata,
  output logic                     abuf_rd,
  output logic [ADDR_W-1:0]        abuf_addr,
  input  logic [N*DATA_W-1:0]      abuf_rdata,
  output logic                     arr_w_load,
  output logic [$clog2(N)-1:0]     arr_w_row,
  output logic [N*DATA_W-1:0]      arr_w_data,
  output logic                     arr_acc_clr,
  output logic [N*DATA_W-1:0]      arr_a_data,
  input  logic [N*N*ACC_W-1:0]     arr_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [N*N*ACC_W-1:0]     res_data,
  output logic [BATCH_W-1:0]       res_tile
);
  localparam int RW  = $clog2(N);
  localparam int DRN = N + ARR_LAT;
  localparam int DCW = $clog2(DRN + 1);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM_A, DRAIN, OUTPUT} state_t;
  state_t state;
  logic [ADDR_W-1:0] abase;
  logic [BATCH_W-1:0] batches, b, b_nxt;
  logic [RW-1:0] r;
  logic [DCW-1:0] dcnt;
  logic a_vld, last_r;
  logic [N*DATA_W-1:0] a_row;
  assign b_nxt = b + 1'b1;
  assign last_r = r == RW'(N-1);
  // Buffers return data one cycle after the strobe; gate so idle lanes carry zeros.
  assign a_row = a_vld ? abuf_rdata : '0;
  assign arr_w_data = arr_w_load ? wbuf_rdata : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      wbuf_rd <= 1'b0;
      wbuf_addr <= '0;
      abuf_rd <= 1'b0;
      abuf_addr <= '0;
      arr_w_load <= 1'b0;
      arr_w_row <= '0;
      arr_acc_clr <= 1'b0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_tile <= '0;
      abase <= '0;
      batches <= '0;
      b <= '0;
      r <= '0;
      dcnt <= '0;
      a_vld <= 1'b0;
    end else begin
      done <= 1'b0;
      a_vld <= abuf_rd;
      arr_w_load <= wbuf_rd;
      arr_w_row <= r;
      arr_acc_clr <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (cfg_batches == '0) done <= 1'b1;
          else begin
            state <= LOAD_W;
            busy <= 1'b1;
            wbuf_rd <= 1'b1;
            wbuf_addr <= cfg_wbase;
            abase <= cfg_abase;
            batches <= cfg_batches;
            b <= '0;
            r <= '0;
          end
        end
        LOAD_W: begin
          r <= last_r ? '0 : r + 1'b1;
          if (last_r) begin
            state <= STREAM_A;
            wbuf_rd <= 1'b0;
            abuf_rd <= 1'b1;
            abuf_addr <= abase;
            arr_acc_clr <= 1'b1;
          end else wbuf_addr <= wbuf_addr + 1'b1;
        end
        STREAM_A: begin
          r <= last_r ? '0 : r + 1'b1;
          if (last_r) begin
            state <= DRAIN;
            abuf_rd <= 1'b0;
            dcnt <= '0;
          end else abuf_addr <= abuf_addr + 1'b1;
        end
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == DCW'(DRN-1)) begin
            state <= OUTPUT;
            res_valid <= 1'b1;
            res_data <= arr_result;
            res_tile <= b;
          end
        end
        OUTPUT: if (res_ready) begin
          res_valid <= 1'b0;
          if (b_nxt == batches) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            state <= STREAM_A;
            b <= b_nxt;
            abuf_rd <= 1'b1;
            abuf_addr <= abase + ADDR_W'(b_nxt) * ADDR_W'(N);
            arr_acc_clr <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign arr_a_data[DATA_W-1:0] = a_row[DATA_W-1:0];
  // Lane j is delayed j extra cycles so rows enter the array diagonally.
  for (genvar j = 1; j < N; j++) begin : g_lane
    logic [DATA_W-1:0] sr [j];
    always_ff @(posedge clk) begin
      if (rst) for (int k = 0; k < j; k++) sr[k] <= '0;
      else begin
        sr[0] <= a_row[j*DATA_W +: DATA_W];
        for (int k = 1; k < j; k++) sr[k] <= sr[k-1];
      end
    end
    assign arr_a_data[j*DATA_W +: DATA_W] = sr[j-1];
  end
endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// tb_systolic_tile_sequencer: self-checking bench with buffer and array models; results are
// compared against a plain matrix product of each activation tile with the weight tile.
module tb_systolic_tile_sequencer;
  localparam int N = 4, DW = 8, AW = 32, ADW = 8, BW = 4, LAT = 2*N;
  logic clk = 0, rst = 1, start = 0, res_ready = 0;
  logic [ADW-1:0] cfg_wbase = '0, cfg_abase = '0;
  logic [BW-1:0] cfg_batches = '0;
  logic busy, done, wbuf_rd, abuf_rd, arr_w_load, arr_acc_clr, res_valid;
  logic [ADW-1:0] wbuf_addr, abuf_addr;
  logic [N*DW-1:0] wbuf_rdata = '0, abuf_rdata = '0, arr_w_data, arr_a_data;
  logic [$clog2(N)-1:0] arr_w_row;
  logic [N*N*AW-1:0] arr_result = '0, res_data;
  logic [BW-1:0] res_tile;

  systolic_tile_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_wbase(cfg_wbase), .cfg_abase(cfg_abase),
    .cfg_batches(cfg_batches), .busy(busy), .done(done), .wbuf_rd(wbuf_rd), .wbuf_addr(wbuf_addr),
    .wbuf_rdata(wbuf_rdata), .abuf_rd(abuf_rd), .abuf_addr(abuf_addr), .abuf_rdata(abuf_rdata),
    .arr_w_load(arr_w_load), .arr_w_row(arr_w_row), .arr_w_data(arr_w_data),
    .arr_acc_clr(arr_acc_clr), .arr_a_data(arr_a_data), .arr_result(arr_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tile(res_tile));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // buffer models: registered read, one-cycle latency
  logic [N*DW-1:0] wmem [256], amem [256];
  always @(posedge clk) begin
    if (wbuf_rd) wbuf_rdata <= wmem[wbuf_addr];
    if (abuf_rd) abuf_rdata <= amem[abuf_addr];
  end

  // behavioural weight-stationary array: lane k at t=r+1+k after clear carries A[r][k]
  int W[N][N], acc[N][N], t = 1000;
  always @(negedge clk) begin
    if (arr_w_load) for (int c = 0; c < N; c++) W[arr_w_row][c] = int'($signed(arr_w_data[c*DW +: DW]));
    if (arr_acc_clr) begin
      t = 0;
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] = 0;
    end else if (t < 1000) t++;
    for (int k = 0; k < N; k++)
      if (t-1-k >= 0 && t-1-k < N)
        for (int c = 0; c < N; c++) acc[t-1-k][c] += int'($signed(arr_a_data[k*DW +: DW])) * W[k][c];
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) arr_result[(i*N+j)*AW +: AW] = acc[i][j];
  end

  // activity monitor, cycle numbers relative to the cycle in which start was high
  int cyc = 0, s_cyc = 0, done_n = 0;
  bit mon_on = 0;
  int w_addr_q[$], w_rel_q[$], wl_rel_q[$], a_addr_q[$], clr_rel_q[$];
  int first_nz[N], nz_n[N];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mon_on) begin
    if (wbuf_rd) begin w_addr_q.push_back(int'(wbuf_addr)); w_rel_q.push_back(cyc - s_cyc); end
    if (arr_w_load) wl_rel_q.push_back(cyc - s_cyc);
    if (abuf_rd) a_addr_q.push_back(int'(abuf_addr));
    if (arr_acc_clr) clr_rel_q.push_back(cyc - s_cyc);
    if (done) done_n++;
    for (int j = 0; j < N; j++)
      if (arr_a_data[j*DW +: DW] != 0) begin
        nz_n[j]++;
        if (first_nz[j] < 0) first_nz[j] = cyc - s_cyc;
      end
  end

  task automatic clear_logs();
    w_addr_q.delete(); w_rel_q.delete(); wl_rel_q.delete(); a_addr_q.delete(); clr_rel_q.delete();
    done_n = 0;
    for (int j = 0; j < N; j++) begin first_nz[j] = -1; nz_n[j] = 0; end
  endtask

  function automatic bit all_zero();
    return (busy | done | wbuf_rd | abuf_rd | arr_w_load | arr_acc_clr | res_valid |
            (|wbuf_addr) | (|abuf_addr) | (|arr_w_row) | (|arr_w_data) | (|arr_a_data) |
            (|res_data) | (|res_tile)) == 1'b0;
  endfunction

  int Am[3][N][N], Bm[N][N];
  int sc[3] = '{1, 2, -1};

  // kind: 0 scaled identity tiles, 1 all-ones tiles, 2 random tiles and weights
  task automatic run_job(input int wb, ab, nb, hold, kind, bs, rst_at, exp_wrd, exp_ard);
    int tile, guard, nbad, bi, bj, e, be, ba;
    bit good;
    logic [N*N*AW-1:0] snap;
    logic [N*DW-1:0] row;
    for (int k = 0; k < N; k++) for (int c = 0; c < N; c++)
      Bm[k][c] = kind == 2 ? int'($urandom_range(0, 255)) - 128 : k + c + 1;
    for (int b = 0; b < nb; b++) for (int r = 0; r < N; r++) for (int k = 0; k < N; k++)
      Am[b][r][k] = kind == 0 ? (r == k ? sc[b] : 0) : kind == 1 ? 1 : int'($urandom_range(0, 255)) - 128;
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < N; k++) row[k*DW +: DW] = DW'(Bm[r][k]);
      wmem[(wb + r) & 255] = row;
    end
    for (int b = 0; b < nb; b++) for (int r = 0; r < N; r++) begin
      for (int k = 0; k < N; k++) row[k*DW +: DW] = DW'(Am[b][r][k]);
      amem[(ab + b*N + r) & 255] = row;
    end
    clear_logs();
    @(negedge clk);
    cfg_wbase = ADW'(wb); cfg_abase = ADW'(ab); cfg_batches = BW'(nb);
    start = 1; s_cyc = cyc; mon_on = 1;
    @(negedge clk);
    start = 0;
    chk("busy_rise", busy, 1);
    tile = 0; guard = 0;
    while (tile < nb && guard < 500) begin
      @(negedge clk);
      guard++;
      start = bs != 0 && cyc - s_cyc == 2*N + 3;
      if (start) begin cfg_wbase = 8'h77; cfg_abase = 8'h99; cfg_batches = BW'(5); end
      if (rst_at > 0 && cyc - s_cyc == rst_at) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_mid_outputs_zero", all_zero(), 1);
        good = 1;
        repeat (30) begin
          @(negedge clk);
          good &= (busy | done | res_valid | wbuf_rd | abuf_rd) == 1'b0;
        end
        chk("rst_mid_quiet", good, 1);
        mon_on = 0;
        chk("rst_mid_no_done", done_n, 0);
        return;
      end
      if (res_valid) begin
        if (tile == 0) chk("res_valid_latency", cyc - s_cyc, 3*N + LAT + 1);
        nbad = 0; bi = 0; bj = 0; be = 0; ba = 0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
          e = 0;
          for (int k = 0; k < N; k++) e += Am[tile][i][k] * Bm[k][j];
          if (res_data[(i*N+j)*AW +: AW] != AW'(e)) begin
            if (nbad == 0) begin bi = i; bj = j; be = e; ba = int'(res_data[(i*N+j)*AW +: AW]); end
            nbad++;
          end
        end
        chk($sformatf("res_data_bad_elems_tile%0d", tile), nbad, 0);
        if (nbad != 0) $display("  first bad element (%0d,%0d): got %0d want %0d", bi, bj, ba, be);
        chk("res_tile", res_tile, tile);
        snap = res_data; good = 1;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          good &= res_data == snap && res_valid && !abuf_rd && res_tile == BW'(tile);
        end
        if (hold > 0) chk("backpressure_hold", good, 1);
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        tile++;
        if (tile < nb) begin
          chk("next_stream_start", abuf_rd && arr_acc_clr, 1);
          chk("next_tile_addr", abuf_addr, (ab + tile*N) & 255);
        end else begin
          chk("done_pulse", done, 1);
          chk("busy_fall", busy, 0);
        end
      end
    end
    chk("job_complete", tile, nb);
    repeat (3) @(negedge clk);
    mon_on = 0;
    chk("done_count", done_n, 1);
    chk("wbuf_rd_cycles", w_addr_q.size(), exp_wrd);
    good = 1;
    foreach (w_addr_q[i]) good &= w_addr_q[i] == ((wb + i) & 255) && w_rel_q[i] == 1 + i;
    chk("wbuf_addr_seq", good, 1);
    good = wl_rel_q.size() == N;
    foreach (wl_rel_q[i]) good &= wl_rel_q[i] == 2 + i;
    chk("w_load_cycles", good, 1);
    chk("abuf_rd_cycles", a_addr_q.size(), exp_ard);
    good = 1;
    foreach (a_addr_q[i]) good &= a_addr_q[i] == ((ab + i) & 255);
    chk("abuf_addr_seq", good, 1);
    chk("first_acc_clr", clr_rel_q.size() > 0 ? clr_rel_q[0] : -1, N + 1);
    chk("acc_clr_count", clr_rel_q.size(), nb);
    if (kind == 1)
      for (int j = 0; j < N; j++) begin
        chk($sformatf("skew_first_lane%0d", j), first_nz[j], N + 2 + j);
        chk($sformatf("skew_len_lane%0d", j), nz_n[j], N);
      end
  endtask

  typedef struct {
    int wb, ab, nb, hold, kind, bs, exp_wrd, exp_ard;
  } vec_t;
  vec_t vt[5];

  initial begin
    vt[0] = '{'h10, 'h20, 1, 0, 0, 0, 4, 4};
    vt[1] = '{'h00, 'h40, 1, 0, 1, 0, 4, 4};
    vt[2] = '{'h10, 'h20, 3, 0, 0, 0, 4, 12};
    vt[3] = '{'h30, 'h50, 2, 10, 0, 1, 4, 8};
    vt[4] = '{'hFE, 'hF8, 3, 2, 2, 0, 4, 12};
    clear_logs();
    rst = 1; start = 1; cfg_batches = 1;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", all_zero(), 1);
    rst = 0; start = 0;
    @(negedge clk);
    chk("rst_beats_start", busy, 0);
    for (int i = 0; i < 5; i++)
      run_job(vt[i].wb, vt[i].ab, vt[i].nb, vt[i].hold, vt[i].kind, vt[i].bs, 0, vt[i].exp_wrd, vt[i].exp_ard);
    clear_logs();
    @(negedge clk);
    cfg_batches = 0; start = 1; s_cyc = cyc; mon_on = 1;
    @(negedge clk);
    start = 0;
    chk("zero_batch_done", done, 1);
    chk("zero_batch_busy", busy, 0);
    @(negedge clk);
    chk("zero_batch_done_once", done, 0);
    repeat (5) @(negedge clk);
    mon_on = 0;
    chk("zero_batch_no_activity", w_addr_q.size() + a_addr_q.size() + wl_rel_q.size(), 0);
    run_job('h10, 'h20, 1, 0, 0, 0, N + 2, 4, 4);
    run_job('h10, 'h20, 1, 0, 0, 0, 0, 4, 4);
    for (int i = 0; i < 4; i++) begin
      int nb;
      nb = int'($urandom_range(1, 3));
      run_job(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), nb,
              int'($urandom_range(0, 3)), 2, 0, 0, N, nb*N);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
